uart_tx_arbiter: RTL

//   Shares one UART transmitter (8-bit byte-start/busy interface) between NUM_REQ

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// State encoding, ACK wait bound and grant index width.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int ACK_WAIT_MAX = 2;

    function automatic int grant_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above the pointer, wrapping around the request vector.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic               o_found,
    output logic [GRANT_W-1:0] o_idx
);

    int w_j;

    // Scan from the far end so the entry nearest the pointer wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = GRANT_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of one UART TX core.
// Optional LOAD-stall release enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = 8,
    parameter  int TIMEOUT_CYCLES = 1_000_000,
    localparam int GRANT_W        = grant_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        s_valid,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_last,
    output logic [NUM_REQ-1:0]        s_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      busy,
    output logic                      grant_valid,
    output logic [GRANT_W-1:0]        grant_idx,
    output logic                      timeout_err
);

    arb_state_e         r_state;
    arb_state_e         w_next;
    logic [GRANT_W-1:0] r_ptr;
    logic [GRANT_W-1:0] r_grant_idx;
    logic               r_grant_valid;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_last;
    logic               r_tx_start;
    logic [1:0]         r_ack_cnt;
    logic               r_timeout_err;

    logic               w_found;
    logic [GRANT_W-1:0] w_pick;
    logic [GRANT_W-1:0] w_ptr_nxt;
    logic               w_hs;
    logic               w_to;
    logic               w_release;
    logic [DATA_W-1:0]  w_byte;
    int                 w_gsel;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (s_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_gsel = int'(r_grant_idx);
    assign w_byte = s_data[w_gsel*DATA_W +: DATA_W];
    assign w_hs   = s_valid[w_gsel] & s_ready[w_gsel];

    always_comb begin
        s_ready = '0;
        if (r_state == LOAD && !tx_busy) begin
            s_ready[w_gsel] = 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;

    assign w_to = (r_state == LOAD) && !w_hs
                && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive LOAD cycles without a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_state == LOAD && !w_hs && !w_to) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_to;

    assign w_unused_to = (TIMEOUT_CYCLES != 0);
    assign w_to        = 1'b0;
`endif

    assign w_ptr_nxt = (r_grant_idx == GRANT_W'(NUM_REQ - 1))
                     ? '0 : r_grant_idx + 1'b1;

    assign w_release = (r_state == WAIT_DONE && !tx_busy && r_last) || w_to;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_found) w_next = LOAD;
            end
            LOAD: begin
                if (w_hs)      w_next = WAIT_ACK;
                else if (w_to) w_next = IDLE;
            end
            WAIT_ACK: begin
                if (tx_busy || r_ack_cnt == 2'(ACK_WAIT_MAX - 1))
                    w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) w_next = r_last ? IDLE : LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_tx_data     <= '0;
            r_last        <= 1'b0;
            r_tx_start    <= 1'b0;
            r_ack_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_tx_start    <= 1'b0;
            r_timeout_err <= w_to;
            if (r_state == IDLE && w_found) begin
                r_grant_idx   <= w_pick;
                r_grant_valid <= 1'b1;
            end
            if (w_hs) begin
                r_tx_data  <= w_byte;
                r_last     <= s_last[w_gsel];
                r_tx_start <= 1'b1;
            end
            if (r_state == WAIT_ACK) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end else begin
                r_ack_cnt <= '0;
            end
            if (w_release) begin
                r_grant_valid <= 1'b0;
                r_ptr         <= w_ptr_nxt;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign busy        = (r_state != IDLE);
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout_err = r_timeout_err;

endmodule
